// File: rtl/mem_arb_pkg.sv
// Shared types for the mem_read arbiter: FSM state encoding and requester ids.
// Latency: n/a (types only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GNT_IF = 2'd1,
        GNT_LS = 2'd2
    } arb_state_t;

    localparam logic SRC_IF = 1'b0;
    localparam logic SRC_LS = 1'b1;

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Requester and memory-side read signals of the arbiter, bundled.
// Latency: n/a (wires only).
// Backpressure: en is a level request held until valid; no ready path exists.
interface mem_read_arbiter_if #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
);
    logic              if_en;
    logic [ADDR_W-1:0] if_addr;
    logic              if_valid;
    logic [DATA_W-1:0] if_rdata;

    logic              ls_en;
    logic [ADDR_W-1:0] ls_addr;
    logic              ls_valid;
    logic [DATA_W-1:0] ls_rdata;

    logic              m_en;
    logic [ADDR_W-1:0] m_addr;
    logic              m_valid;
    logic [DATA_W-1:0] m_rdata;

    // Arbiter side.
    modport slave (
        input  if_en, if_addr, ls_en, ls_addr, m_valid, m_rdata,
        output if_valid, if_rdata, ls_valid, ls_rdata, m_en, m_addr
    );

    // Requesters plus memory, as seen from outside the arbiter.
    modport master (
        output if_en, if_addr, ls_en, ls_addr, m_valid, m_rdata,
        input  if_valid, if_rdata, ls_valid, ls_rdata, m_en, m_addr
    );
endinterface

// File: rtl/mem_arb_timer.sv
// Counts granted cycles without a memory response and flags when TIMEOUT is reached.
// Latency: hit is combinational from the registered count.
// Backpressure: none; count saturates at TIMEOUT, TIMEOUT=0 disables hit.
module mem_arb_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic ACLK,
    input  logic ARESET,
    input  logic clr,
    input  logic inc,
    output logic hit
);
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] wait_cnt;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && (wait_cnt != LIMIT)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    assign hit = (TIMEOUT != 0) && (wait_cnt == LIMIT);

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin share of one mem_read port between IF and LS, one read outstanding.
// Latency: en sampled at edge N, m_en from N+1; requester valid in the m_valid cycle.
// Backpressure: a pending requester waits in en until granted; grant held until m_valid or timeout.
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    mem_read_arbiter_if.slave       bus,
    output logic                    busy,
    output logic                    timeout_err
);
    arb_state_t        state;
    arb_state_t        state_nxt;
    logic              rr_last;
    logic [ADDR_W-1:0] m_addr_q;
    logic              tmr_hit;
    logic              granted;
    logic              grant_edge;

    assign granted    = (state != IDLE);
    assign grant_edge = (state == IDLE) && (state_nxt != IDLE);

    mem_arb_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .clr    (state == IDLE),
        .inc    (granted && !bus.m_valid),
        .hit    (tmr_hit)
    );

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // IF wins a tie unless it was the last side served.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (bus.if_en && (!bus.ls_en || (rr_last == SRC_LS))) begin
                    state_nxt = GNT_IF;
                end else if (bus.ls_en) begin
                    state_nxt = GNT_LS;
                end
            end
            GNT_IF, GNT_LS: begin
                if (bus.m_valid || tmr_hit) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rr_last     <= SRC_LS;
            m_addr_q    <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (grant_edge) begin
                m_addr_q <= (state_nxt == GNT_IF) ? bus.if_addr : bus.ls_addr;
                rr_last  <= (state_nxt == GNT_IF) ? SRC_IF : SRC_LS;
            end
            // A response arriving in the hit cycle completes normally.
            if (granted && tmr_hit && !bus.m_valid) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_comb begin
        busy         = granted;
        bus.m_en     = granted;
        bus.m_addr   = m_addr_q;
        bus.if_rdata = bus.m_rdata;
        bus.ls_rdata = bus.m_rdata;
        bus.if_valid = (state == GNT_IF) && bus.m_valid && bus.if_en;
        bus.ls_valid = (state == GNT_LS) && bus.m_valid && bus.ls_en;
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Directed scenarios then random traffic against a transaction-level reference model.
// Latency: checks each cycle one time unit after inputs change, away from the clock edge.
// Backpressure: bench memory answers after a chosen number of granted cycles or never.
module tb_mem_read_arbiter;
    localparam int AW  = 64;
    localparam int DW  = 64;
    localparam int TMO = 8;

    logic ACLK = 1'b0;
    logic ARESET;
    logic busy;
    logic timeout_err;

    mem_read_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    mem_read_arbiter #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .TIMEOUT (TMO)
    ) dut (
        .ACLK        (ACLK),
        .ARESET      (ARESET),
        .bus         (bus),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    always #5 ACLK = ~ACLK;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: who owns the port (0 none, 1 IF, 2 LS) and its history.
    int          ref_owner;
    bit          ref_last_ls;
    logic [63:0] ref_addr;
    int          ref_wait;
    bit          ref_err;

    // Bench memory and requester behaviour.
    int          mem_lat;
    int          mem_cnt;
    bit          mem_fix;
    logic [63:0] mem_dat;
    bit          stray_en;
    bit          rand_mem;
    bit          drop_on_valid;
    bit          rand_req;

    // Observations.
    logic [63:0] grant_log[$];
    bit          prev_men;
    int          ifv_seen, lsv_seen, men_hi;
    logic [63:0] last_if_rdata;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_reset();
        ref_owner   = 0;
        ref_last_ls = 1'b1;
        ref_addr    = '0;
        ref_wait    = 0;
        ref_err     = 1'b0;
        mem_cnt     = 0;
        prev_men    = 1'b0;
    endtask

    task automatic clear_obs();
        grant_log.delete();
        ifv_seen = 0;
        lsv_seen = 0;
        men_hi   = 0;
    endtask

    task automatic do_reset();
        ARESET      = 1'b1;
        bus.if_en   = 1'b0;
        bus.ls_en   = 1'b0;
        bus.if_addr = '0;
        bus.ls_addr = '0;
        bus.m_valid = 1'b0;
        bus.m_rdata = '0;
        @(posedge ACLK);
        @(negedge ACLK);
        ARESET = 1'b0;
        ref_reset();
    endtask

    // One clock: drive memory, check every output, advance the model, cross the edge.
    task automatic tick();
        logic        mv;
        logic [63:0] rd;
        bit          e_ifv, e_lsv;
        int          pick;
        if (bus.m_en && mem_cnt == 0 && rand_mem) mem_lat = $urandom_range(0, 9);
        mv = 1'b0;
        if (bus.m_en) mv = (mem_lat >= 0) && (mem_cnt == mem_lat);
        else if (stray_en) mv = ($urandom_range(0, 7) == 0);
        rd = mem_fix ? mem_dat : {$urandom, $urandom};
        bus.m_valid = mv;
        bus.m_rdata = rd;
        #1;
        e_ifv = (ref_owner == 1) && mv && bus.if_en;
        e_lsv = (ref_owner == 2) && mv && bus.ls_en;
        chk("busy",        64'(busy),         64'(ref_owner != 0));
        chk("m_en",        64'(bus.m_en),     64'(ref_owner != 0));
        chk("m_addr",      bus.m_addr,        ref_addr);
        chk("if_valid",    64'(bus.if_valid), 64'(e_ifv));
        chk("ls_valid",    64'(bus.ls_valid), 64'(e_lsv));
        chk("if_rdata",    bus.if_rdata,      rd);
        chk("ls_rdata",    bus.ls_rdata,      rd);
        chk("timeout_err", 64'(timeout_err),  64'(ref_err));
        if (bus.m_en && !prev_men) grant_log.push_back(bus.m_addr);
        prev_men = bus.m_en;
        men_hi  += int'(bus.m_en);
        if (bus.if_valid) begin
            ifv_seen++;
            last_if_rdata = bus.if_rdata;
        end
        if (bus.ls_valid) lsv_seen++;
        if (ref_owner == 0) begin
            pick = 0;
            if (bus.if_en && bus.ls_en) pick = ref_last_ls ? 1 : 2;
            else if (bus.if_en)         pick = 1;
            else if (bus.ls_en)         pick = 2;
            if (pick != 0) begin
                ref_owner   = pick;
                ref_addr    = (pick == 1) ? bus.if_addr : bus.ls_addr;
                ref_last_ls = (pick == 2);
                ref_wait    = 0;
            end
        end else if (mv) begin
            ref_owner = 0;
        end else if (TMO != 0 && ref_wait == TMO) begin
            ref_err   = 1'b1;
            ref_owner = 0;
        end else begin
            ref_wait++;
        end
        mem_cnt = bus.m_en ? mem_cnt + 1 : 0;
        @(posedge ACLK);
        @(negedge ACLK);
        bus.m_valid = 1'b0;
        if (drop_on_valid) begin
            if (e_ifv && (!rand_req || $urandom_range(0, 3) != 0)) bus.if_en = 1'b0;
            if (e_lsv && (!rand_req || $urandom_range(0, 3) != 0)) bus.ls_en = 1'b0;
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic rand_requesters();
        if (!bus.if_en) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.if_en   = 1'b1;
                bus.if_addr = {$urandom, $urandom};
            end
        end else if ($urandom_range(0, 15) == 0) begin
            bus.if_en = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
            bus.if_addr = {$urandom, $urandom};
        end
        if (!bus.ls_en) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.ls_en   = 1'b1;
                bus.ls_addr = {$urandom, $urandom};
            end
        end else if ($urandom_range(0, 15) == 0) begin
            bus.ls_en = 1'b0;
        end else if ($urandom_range(0, 7) == 0) begin
            bus.ls_addr = {$urandom, $urandom};
        end
    endtask

    initial begin
        mem_lat = 3; mem_fix = 1'b0; mem_dat = '0; stray_en = 1'b0;
        rand_mem = 1'b0; drop_on_valid = 1'b1; rand_req = 1'b0;
        last_if_rdata = '0;
        ARESET = 1'b1;
        ref_reset();
        clear_obs();
        do_reset();

        // Reset state.
        #1;
        chk("rst_m_en",   64'(bus.m_en),     64'd0);
        chk("rst_m_addr", bus.m_addr,        64'd0);
        chk("rst_busy",   64'(busy),         64'd0);
        chk("rst_err",    64'(timeout_err),  64'd0);
        chk("rst_ifv",    64'(bus.if_valid), 64'd0);
        chk("rst_lsv",    64'(bus.ls_valid), 64'd0);
        @(negedge ACLK);

        // 1: IF alone, memory answers 3 cycles after m_en rises.
        mem_fix = 1'b1; mem_dat = 64'h13; mem_lat = 3;
        bus.if_en = 1'b1; bus.if_addr = 64'h8000_0000;
        ticks(8);
        chk("t1_addr",  (grant_log.size() > 0) ? grant_log[0] : 64'hdead, 64'h8000_0000);
        chk("t1_ifv",   64'(ifv_seen), 64'd1);
        chk("t1_lsv",   64'(lsv_seen), 64'd0);
        chk("t1_rdata", last_if_rdata, 64'h13);
        mem_fix = 1'b0;

        // 2: tie right after reset goes to IF, then LS.
        do_reset(); clear_obs();
        mem_lat = 2;
        bus.if_en = 1'b1; bus.if_addr = 64'h100;
        bus.ls_en = 1'b1; bus.ls_addr = 64'h200;
        ticks(12);
        chk("t2_ngrant", 64'(grant_log.size()), 64'd2);
        chk("t2_first",  (grant_log.size() > 0) ? grant_log[0] : 64'hdead, 64'h100);
        chk("t2_second", (grant_log.size() > 1) ? grant_log[1] : 64'hdead, 64'h200);
        chk("t2_lsv",    64'(lsv_seen), 64'd1);

        // 3: both held high, grants alternate.
        clear_obs();
        drop_on_valid = 1'b0; mem_lat = 1;
        bus.if_en = 1'b1; bus.ls_en = 1'b1;
        ticks(12);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_grant%0d", i),
                (grant_log.size() > i) ? grant_log[i] : 64'hdead,
                (i % 2 == 0) ? 64'h100 : 64'h200);
        bus.if_en = 1'b0; bus.ls_en = 1'b0;
        drop_on_valid = 1'b1;
        ticks(4);

        // 4: LS abandons one cycle after grant, IF follows normally.
        clear_obs();
        mem_lat = 3;
        bus.ls_en = 1'b1; bus.ls_addr = 64'h300;
        tick();
        tick();
        bus.ls_en = 1'b0;
        ticks(5);
        bus.if_en = 1'b1; bus.if_addr = 64'h400;
        ticks(8);
        chk("t4_lsv",  64'(lsv_seen), 64'd0);
        chk("t4_ifv",  64'(ifv_seen), 64'd1);
        chk("t4_last", (grant_log.size() > 0) ? grant_log[grant_log.size()-1] : 64'hdead, 64'h400);

        // 5: memory never answers; grant lasts TMO no-response cycles plus the hit cycle.
        clear_obs();
        mem_lat = -1;
        bus.if_en = 1'b1; bus.if_addr = 64'h500;
        tick();
        bus.if_en = 1'b0;
        ticks(14);
        chk("t5_men_cycles", 64'(men_hi), 64'(TMO + 1));
        chk("t5_err",  64'(timeout_err), 64'd1);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_ifv",  64'(ifv_seen), 64'd0);

        // 6: async reset mid GNT_LS, then a stray m_valid.
        bus.ls_en = 1'b1; bus.ls_addr = 64'h600;
        tick();
        tick();
        chk("t6_pre_busy", 64'(busy), 64'd1);
        #2;
        ARESET = 1'b1;
        #1;
        chk("t6_m_en",   64'(bus.m_en),    64'd0);
        chk("t6_busy",   64'(busy),        64'd0);
        chk("t6_m_addr", bus.m_addr,       64'd0);
        chk("t6_err",    64'(timeout_err), 64'd0);
        bus.m_valid = 1'b1;
        #1;
        chk("t6_lsv", 64'(bus.ls_valid), 64'd0);
        chk("t6_ifv", 64'(bus.if_valid), 64'd0);
        @(negedge ACLK);
        bus.m_valid = 1'b0;
        bus.ls_en   = 1'b0;
        ARESET      = 1'b0;
        ref_reset();

        // Random traffic with stray responses, abandons and boundary latencies.
        stray_en = 1'b1; rand_mem = 1'b1; rand_req = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) do_reset();
            rand_requesters();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
